spi_transfer_core: RTL and testbench

- Single-clock SPI master datapath that combines a transfer sequencer with a configurable-length bidirectional shift register.
- Software configures the transfer length, chip-select setup delay and bit order through a two-entry parameter bus.
- A start pulse loads the transmit word, frames it with chip-select and shifts it out on MOSI while capturing MISO.
- It sits between the control unit (data source/sink) and the SPI pins; spi_sclk is a free-running shift clock from an external divider.

---
 rtl/spi_transfer_core.sv | 200 ++++++++++++++++++++
 tb/tb_spi_transfer_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer_core.sv
// SPI master transfer core: sequencer plus variable-length shift register.
// Length, CS setup delay and bit order are latched from parameter registers at start.
module spi_transfer_core #(
    parameter int DATA_WIDTH  = 32,
    parameter int DELAY_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  parameter_address,
    input  logic [31:0]           parameter_data,
    input  logic                  parameter_write_enable,
    input  logic                  spi_sclk,
    input  logic                  spi_start_transfer,
    input  logic [DATA_WIDTH-1:0] cu_data_out,
    input  logic                  spi_miso,
    output logic [DATA_WIDTH-1:0] reg_data_out,
    output logic                  spi_mosi,
    output logic                  spi_cs_n,
    output logic                  sclk_enable,
    output logic                  busy,
    output logic                  transfer_done
);

    localparam int LW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          cfg_len_q, cfg_len_d;
    logic [DELAY_WIDTH-1:0] cfg_delay_q, cfg_delay_d;
    logic                   cfg_lsb_q, cfg_lsb_d;
    logic [LW-1:0]          len_q, len_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic                   lsb_q, lsb_d;
    logic [DELAY_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0]  sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_en_q, sclk_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sclk_q;

    logic                   rise;
    logic [IW-1:0]          top;
    logic [DATA_WIDTH-1:0]  sh;
    logic                   unused_pdata;

    assign unused_pdata = ^parameter_data[31:9];

    function automatic logic [DATA_WIDTH-1:0] len_mask(input logic [LW-1:0] l);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    assign rise = spi_sclk & ~sclk_q;
    assign top  = IW'(len_q - LW'(1));

    always_comb begin
        sh = '0;
        if (lsb_q) begin
            sh      = sreg_q >> 1;
            sh[top] = spi_miso;
        end else begin
            sh = ((sreg_q << 1) | DATA_WIDTH'(spi_miso)) & len_mask(len_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_len_d   = cfg_len_q;
        cfg_delay_d = cfg_delay_q;
        cfg_lsb_d   = cfg_lsb_q;
        len_d       = len_q;
        delay_d     = delay_q;
        lsb_d       = lsb_q;
        dcnt_d      = dcnt_q;
        bcnt_d      = bcnt_q;
        sreg_d      = sreg_q;
        rdata_d     = rdata_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        sclk_en_d   = sclk_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Out-of-range lengths fall back to the full word width.
        if (parameter_write_enable) begin
            if (!parameter_address) begin
                if (parameter_data[5:0] == 6'd0 ||
                    int'(parameter_data[5:0]) > DATA_WIDTH) begin
                    cfg_len_d = LW'(DATA_WIDTH);
                end else begin
                    cfg_len_d = LW'(parameter_data[5:0]);
                end
            end else begin
                cfg_delay_d = parameter_data[DELAY_WIDTH-1:0];
                cfg_lsb_d   = parameter_data[8];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (spi_start_transfer) begin
                    len_d   = cfg_len_q;
                    delay_d = cfg_delay_q;
                    lsb_d   = cfg_lsb_q;
                    sreg_d  = cu_data_out & len_mask(cfg_len_q);
                    dcnt_d  = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (delay_q == '0 || dcnt_q == delay_q - DELAY_WIDTH'(1)) begin
                    bcnt_d    = '0;
                    sclk_en_d = 1'b1;
                    mosi_d    = lsb_q ? sreg_q[0] : sreg_q[top];
                    state_d   = SHIFT;
                end else begin
                    dcnt_d = dcnt_q + DELAY_WIDTH'(1);
                end
            end
            SHIFT: begin
                if (rise) begin
                    sreg_d = sh;
                    bcnt_d = bcnt_q + LW'(1);
                    mosi_d = lsb_q ? sh[0] : sh[top];
                    if (bcnt_q == len_q - LW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rdata_d   = sreg_q & len_mask(len_q);
                done_d    = 1'b1;
                cs_n_d    = 1'b1;
                sclk_en_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cfg_len_q   <= LW'(DATA_WIDTH);
            cfg_delay_q <= '0;
            cfg_lsb_q   <= 1'b0;
            len_q       <= LW'(DATA_WIDTH);
            delay_q     <= '0;
            lsb_q       <= 1'b0;
            dcnt_q      <= '0;
            bcnt_q      <= '0;
            sreg_q      <= '0;
            rdata_q     <= '0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_len_q   <= cfg_len_d;
            cfg_delay_q <= cfg_delay_d;
            cfg_lsb_q   <= cfg_lsb_d;
            len_q       <= len_d;
            delay_q     <= delay_d;
            lsb_q       <= lsb_d;
            dcnt_q      <= dcnt_d;
            bcnt_q      <= bcnt_d;
            sreg_q      <= sreg_d;
            rdata_q     <= rdata_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            sclk_en_q   <= sclk_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sclk_q      <= spi_sclk;
        end
    end

    assign reg_data_out  = rdata_q;
    assign spi_mosi      = mosi_q;
    assign spi_cs_n      = cs_n_q;
    assign sclk_enable   = sclk_en_q;
    assign busy          = busy_q;
    assign transfer_done = done_q;

endmodule

// File: tb/tb_spi_transfer_core.sv
// Scoreboard bench for spi_transfer_core: expected words queued at start,
// a monitor pops and compares on every transfer_done pulse.
module tb_spi_transfer_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        parameter_address;
    logic [31:0] parameter_data;
    logic        parameter_write_enable;
    logic        spi_sclk;
    logic        spi_start_transfer;
    logic [31:0] cu_data_out;
    logic        spi_miso;
    logic [31:0] reg_data_out;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        sclk_enable;
    logic        busy;
    logic        transfer_done;

    logic        loop_en;
    logic        miso_fix;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt;
    int          rises;
    int          cs_low;
    int          busy_after;
    logic [31:0] mosi_word;
    logic        sclk_prev;
    logic [31:0] exp_q[$];

    assign spi_miso = loop_en ? spi_mosi : miso_fix;

    spi_transfer_core dut (
        .clock                 (clock),
        .reset                 (reset),
        .parameter_address     (parameter_address),
        .parameter_data        (parameter_data),
        .parameter_write_enable(parameter_write_enable),
        .spi_sclk              (spi_sclk),
        .spi_start_transfer    (spi_start_transfer),
        .cu_data_out           (cu_data_out),
        .spi_miso              (spi_miso),
        .reg_data_out          (reg_data_out),
        .spi_mosi              (spi_mosi),
        .spi_cs_n              (spi_cs_n),
        .sclk_enable           (sclk_enable),
        .busy                  (busy),
        .transfer_done         (transfer_done)
    );

    always #5 clock = ~clock;

    // Shift clock: one quarter of the system clock rate, changes 2ns after a rising edge.
    initial begin
        int div;
        div = 0;
        spi_sclk = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (div == 1) begin
                spi_sclk = ~spi_sclk;
                div = 0;
            end else begin
                div++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on done, plus pin activity statistics.
    initial begin
        sclk_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (transfer_done === 1'b1) begin
                done_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: got 0x%08h expected none", reg_data_out);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (reg_data_out !== e) begin
                        n_bad++;
                        $display("FAIL rx_word: got 0x%08h expected 0x%08h", reg_data_out, e);
                    end
                end
            end
            if (spi_sclk && !sclk_prev && sclk_enable) begin
                rises++;
                mosi_word = {mosi_word[30:0], spi_mosi};
            end
            if (!spi_cs_n && !sclk_enable) cs_low++;
            if (busy && rises > 0) busy_after++;
            sclk_prev = spi_sclk;
        end
    end

    task automatic clear_stats();
        done_cnt   = 0;
        rises      = 0;
        cs_low     = 0;
        busy_after = 0;
        mosi_word  = '0;
    endtask

    task automatic pwrite(input logic addr, input logic [31:0] data);
        @(posedge clock);
        #2;
        parameter_address      = addr;
        parameter_data         = data;
        parameter_write_enable = 1'b1;
        @(posedge clock);
        #2;
        parameter_write_enable = 1'b0;
    endtask

    task automatic start(input logic [31:0] data);
        @(posedge clock);
        #2;
        cu_data_out        = data;
        spi_start_transfer = 1'b1;
        @(posedge clock);
        #2;
        spi_start_transfer = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (rises >= n) break;
        end
        check("rise_wait", 32'(rises >= n), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (done_cnt != 0) break;
        end
        check("done_timeout", 32'(done_cnt != 0), 32'd1);
        repeat (12) @(negedge clock);
    endtask

    task automatic run(input string name, input logic [31:0] data, input logic [31:0] exp,
                       input logic lp, input logic mf, input int nbits,
                       input logic [31:0] exp_mosi, input int exp_cs);
        logic [31:0] m;
        m = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        loop_en  = lp;
        miso_fix = mf;
        clear_stats();
        exp_q.push_back(exp);
        start(data);
        wait_done();
        check({name, "_rises"}, 32'(rises), 32'(nbits));
        check({name, "_mosi"}, mosi_word & m, exp_mosi);
        check({name, "_cs_setup"}, 32'(cs_low), 32'(exp_cs));
        check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset                  = 1'b0;
        parameter_address      = 1'b0;
        parameter_data         = '0;
        parameter_write_enable = 1'b0;
        spi_start_transfer     = 1'b0;
        cu_data_out            = '0;
        loop_en                = 1'b1;
        miso_fix               = 1'b0;
        clear_stats();
        repeat (3) @(negedge clock);
        check("rst_reg", reg_data_out, 32'h0);
        check("rst_mosi", 32'(spi_mosi), 32'h0);
        check("rst_cs_n", 32'(spi_cs_n), 32'h1);
        check("rst_sclk_en", 32'(sclk_enable), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(transfer_done), 32'h0);
        @(posedge clock);
        #2 reset = 1'b1;

        pwrite(1'b0, 32'd12);
        pwrite(1'b1, 32'd4);
        run("msb12", 32'h0000_0A5C, 32'h0000_0A5C, 1'b1, 1'b0, 12, 32'h0000_0A5C, 4);

        pwrite(1'b1, 32'h0000_0104);
        pwrite(1'b0, 32'd8);
        run("lsb8", 32'h0000_00B1, 32'h0000_00FF, 1'b0, 1'b1, 8, 32'h0000_008D, 4);

        pwrite(1'b1, 32'h0);
        pwrite(1'b0, 32'h0);
        run("len32", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32, 32'hDEAD_BEEF, 1);

        pwrite(1'b0, 32'd8);
        pwrite(1'b1, 32'd2);
        loop_en = 1'b1;
        clear_stats();
        exp_q.push_back(32'h0000_003C);
        start(32'h0000_003C);
        wait_rises(2);
        @(posedge clock);
        #2;
        spi_start_transfer     = 1'b1;
        cu_data_out            = 32'h0000_00FF;
        parameter_address      = 1'b0;
        parameter_data         = 32'd4;
        parameter_write_enable = 1'b1;
        @(posedge clock);
        #2;
        spi_start_transfer     = 1'b0;
        parameter_write_enable = 1'b0;
        wait_done();
        check("busy_start_rises", 32'(rises), 32'd8);
        check("busy_start_done", 32'(done_cnt), 32'd1);
        run("len4", 32'h0000_0009, 32'h0000_0009, 1'b1, 1'b0, 4, 32'h0000_0009, 2);

        pwrite(1'b0, 32'd16);
        clear_stats();
        loop_en = 1'b1;
        start(32'h0000_1234);
        wait_rises(3);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("abort_cs_n", 32'(spi_cs_n), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_reg", reg_data_out, 32'h0);
        check("abort_sclk_en", 32'(sclk_enable), 32'h0);
        @(posedge clock);
        #2 reset = 1'b1;
        repeat (60) @(negedge clock);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run("after_rst", 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, 1'b0, 32, 32'h0F0F_0F0F, 1);

        pwrite(1'b0, 32'd1);
        pwrite(1'b1, 32'd0);
        run("len1", 32'h0, 32'h0000_0001, 1'b0, 1'b1, 1, 32'h0, 1);
        check("len1_busy_tail", 32'(busy_after <= 4), 32'd1);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
